sntc_ldpc_cword_loader: RTL and testbench

Upstream stage of the LDPC syndrome check. It accepts a received hard-decision codeword as a stream of W-bit beats and packs them into an NN-bit word. The word drives `sntc_ldpc_syndrome_wrapper`'s `y_nr_in`, and the loader captures the MM-bit syndrome that comes back. The loader then presents the codeword, the syndrome and a valid-codeword flag downstream with a valid/ready handshake, one frame at a time.

---
 rtl/sntc_ldpc_cword_loader.sv | 139 +++++++++++++
 tb/tb_sntc_ldpc_cword_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sntc_ldpc_cword_loader.sv
// sntc_ldpc_cword_loader: packs W-bit codeword beats into an NN-bit word for the
// syndrome wrapper, captures the returned syndrome and hands codeword, syndrome
// and status downstream over a valid/ready handshake, one frame at a time.
module sntc_ldpc_cword_loader #(
  parameter int unsigned NN = 208,
  parameter int unsigned MM = 168,
  parameter int unsigned W  = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic [NN-1:0] y_nr_out,
  input  logic [MM-1:0] syn_nr_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NN-1:0] out_cword,
  output logic [MM-1:0] out_syn,
  output logic          out_ok,
  output logic          out_err
);

  localparam int unsigned BEATS = (NN + W - 1) / W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned EXT_W = BEATS * W;
  localparam int unsigned IDX_W = $clog2(EXT_W);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [NN-1:0]      pack, pack_nx;
  logic               err, err_nx;
  logic [EXT_W-1:0]   ext;
  logic [IDX_W-1:0]   base;
  logic               last_pos;

  // The packing register feeds the syndrome wrapper directly; no extra stage.
  assign y_nr_out = pack;

  // Next-state, beat packing and framing-error logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pack_nx  = pack;
    err_nx   = err;
    ext      = EXT_W'(pack);
    base     = IDX_W'(cnt) * IDX_W'(W);
    last_pos = (cnt == CNT_W'(BEATS - 1));

    case (state)
      LOAD: begin
        if (in_valid) begin
          // Write into a beat-aligned extension so the final beat's upper bits
          // fall beyond NN and are dropped by the truncation below.
          ext[base +: W] = in_data;
          pack_nx        = ext[NN-1:0];
          cnt_nx         = cnt + CNT_W'(1);
          if (in_last || last_pos) begin
            cnt_nx   = '0;
            state_nx = CHECK;
            // Early in_last, or a full-length frame without in_last.
            if (in_last != last_pos) err_nx = 1'b1;
          end
        end
      end
      CHECK: begin
        state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = LOAD;
          pack_nx  = '0;
          err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = LOAD;
        cnt_nx   = '0;
        pack_nx  = '0;
        err_nx   = 1'b0;
      end
    endcase
  end

  // State, counter, packing register and handshake flags.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= LOAD;
      cnt       <= '0;
      pack      <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= LOAD;
      cnt       <= '0;
      pack      <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pack      <= pack_nx;
      err       <= err_nx;
      in_ready  <= (state_nx == LOAD);
      out_valid <= (state_nx == HOLD);
    end
  end

  // Result capture while the packed word is stable in CHECK.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_cword <= '0;
      out_syn   <= '0;
      out_ok    <= 1'b0;
      out_err   <= 1'b0;
    end else if (clr) begin
      out_cword <= '0;
      out_syn   <= '0;
      out_ok    <= 1'b0;
      out_err   <= 1'b0;
    end else if (state == CHECK) begin
      out_cword <= pack;
      out_syn   <= syn_nr_in;
      out_ok    <= ~|syn_nr_in;
      out_err   <= err;
    end
  end

endmodule

// File: tb/tb_sntc_ldpc_cword_loader.sv
// Bench for sntc_ldpc_cword_loader: a behavioural H-matrix stands in for the
// syndrome wrapper, and expected frames come from a bit-level frame model.
module tb_sntc_ldpc_cword_loader;

  localparam int unsigned NN    = 208;
  localparam int unsigned MM    = 168;
  localparam int unsigned W     = 24;
  localparam int unsigned BEATS = (NN + W - 1) / W;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [NN-1:0] y_nr_out;
  logic [MM-1:0] syn_nr_in;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NN-1:0] out_cword;
  logic [MM-1:0] out_syn;
  logic          out_ok;
  logic          out_err;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] q_d[$];
  logic         q_l[$];

  sntc_ldpc_cword_loader #(.NN(NN), .MM(MM), .W(W)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .y_nr_out(y_nr_out), .syn_nr_in(syn_nr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cword(out_cword), .out_syn(out_syn), .out_ok(out_ok), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Behavioural H: column j has (up to) three ones; never an all-zero column.
  function automatic logic [MM-1:0] hsyn(input logic [NN-1:0] y);
    logic [MM-1:0] s;
    s = '0;
    for (int j = 0; j < NN; j++) begin
      if (y[j]) begin
        s[(j * 7) % MM]       = ~s[(j * 7) % MM];
        s[(j * 13 + 5) % MM]  = ~s[(j * 13 + 5) % MM];
        s[(j * 29 + 11) % MM] = ~s[(j * 29 + 11) % MM];
      end
    end
    return s;
  endfunction

  always_comb syn_nr_in = hsyn(y_nr_out);

  // Frame model: beats fill bits k*W+i below NN; frame ends at first in_last
  // or at beat BEATS-1; early in_last or missing final in_last is an error.
  function automatic void ref_frame(output logic [NN-1:0] cw, output logic e, output int nb);
    cw = '0; e = 1'b0; nb = 0;
    for (int k = 0; k < BEATS; k++) begin
      for (int i = 0; i < W; i++)
        if (k * W + i < NN) cw[k * W + i] = q_d[k][i];
      nb = k + 1;
      if (q_l[k]) begin
        e = (k != BEATS - 1);
        break;
      end
      if (k == BEATS - 1) e = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present q_d/q_l[0..nb-1], respecting in_ready; returns after the last accept.
  task automatic send_frame(input int nb, input bit gaps, output bit ok);
    int idx;
    int budget;
    bit acc;
    idx = 0; budget = 0; ok = 1'b1;
    while (idx < nb) begin
      if (budget > 300) begin
        ok = 1'b0;
        break;
      end
      if (!gaps || $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = q_d[idx];
        in_last  = q_l[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
      end
      acc = in_valid && in_ready;
      tick();
      budget++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic fill(input logic [W-1:0] d, input int last_at);
    q_d.delete(); q_l.delete();
    for (int k = 0; k < BEATS; k++) begin
      q_d.push_back(d);
      q_l.push_back(k == last_at);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    tick(); tick();
    rstn = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else passed++;
    checks++; if (y_nr_out !== '0) $display("FAIL reset_y: got %h exp 0", y_nr_out); else passed++;
    checks++;
    if ({out_cword, out_syn, out_ok, out_err} !== '0)
      $display("FAIL reset_outs: got cw=%h syn=%h ok=%b err=%b exp all 0", out_cword, out_syn, out_ok, out_err);
    else passed++;
  endtask

  task automatic test_zero_frame();
    bit ok;
    fill('0, BEATS - 1);
    send_frame(BEATS, 1'b0, ok);
    checks++; if (!ok) $display("FAIL zero_send: got timeout exp accepted"); else passed++;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL zero_check_cycle: got rdy=%b vld=%b exp 0 0", in_ready, out_valid);
    else passed++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL zero_latency: got vld=%b exp 1", out_valid); else passed++;
    checks++;
    if (out_syn !== '0 || out_ok !== 1'b1 || out_err !== 1'b0 || out_cword !== '0)
      $display("FAIL zero_result: got syn=%h ok=%b err=%b exp 0 1 0", out_syn, out_ok, out_err);
    else passed++;
    release_out();
  endtask

  task automatic test_single_bit();
    bit ok, got;
    logic [NN-1:0] exp_cw;
    fill('0, BEATS - 1);
    q_d[1] = 24'h002000;
    exp_cw = '0; exp_cw[37] = 1'b1;
    send_frame(BEATS, 1'b1, ok);
    wait_valid(10, got);
    checks++; if (!got) $display("FAIL bit37_valid: got timeout exp out_valid"); else passed++;
    checks++; if (out_cword !== exp_cw) $display("FAIL bit37_cword: got %h exp %h", out_cword, exp_cw); else passed++;
    checks++;
    if (out_syn !== hsyn(exp_cw) || out_syn === '0 || out_ok !== 1'b0)
      $display("FAIL bit37_syn: got syn=%h ok=%b exp syn=%h ok=0", out_syn, out_ok, hsyn(exp_cw));
    else passed++;
    release_out();
  endtask

  task automatic test_last_mask();
    bit ok, got;
    logic [NN-1:0] exp_cw;
    fill('0, BEATS - 1);
    q_d[BEATS - 1] = 24'hFFFFFF;
    exp_cw = '0; exp_cw[207:192] = 16'hFFFF;
    send_frame(BEATS, 1'b0, ok);
    wait_valid(10, got);
    checks++;
    if (!got || out_cword !== exp_cw || out_err !== 1'b0)
      $display("FAIL last_mask: got vld=%b cw=%h err=%b exp cw=%h err=0", got, out_cword, out_err, exp_cw);
    else passed++;
    release_out();
  endtask

  task automatic test_early_last();
    bit ok, got;
    logic [NN-1:0] exp_cw;
    logic e;
    int nb;
    fill('0, 4);
    for (int k = 0; k < BEATS; k++) q_d[k] = W'($urandom) | W'(1);
    ref_frame(exp_cw, e, nb);
    send_frame(nb, 1'b1, ok);
    wait_valid(10, got);
    checks++; if (out_err !== 1'b1 || !got) $display("FAIL early_err: got %b exp 1", out_err); else passed++;
    checks++;
    if (out_cword[207:120] !== '0 || out_cword !== exp_cw)
      $display("FAIL early_cword: got %h exp %h", out_cword, exp_cw);
    else passed++;
    release_out();
    fill(24'h5A5A5A, BEATS - 1);
    ref_frame(exp_cw, e, nb);
    send_frame(nb, 1'b0, ok);
    wait_valid(10, got);
    checks++;
    if (!got || out_err !== 1'b0 || out_cword !== exp_cw)
      $display("FAIL after_early: got err=%b cw=%h exp err=0 cw=%h", out_err, out_cword, exp_cw);
    else passed++;
    release_out();
  endtask

  task automatic test_hold();
    bit ok, got, stable;
    logic [NN-1:0] exp_cw;
    logic e;
    int nb;
    fill('0, BEATS - 1);
    for (int k = 0; k < BEATS; k++) q_d[k] = W'($urandom);
    ref_frame(exp_cw, e, nb);
    send_frame(nb, 1'b0, ok);
    wait_valid(10, got);
    stable = got;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = W'($urandom);
      in_last = 1'($urandom);
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_cword !== exp_cw ||
          out_syn !== hsyn(exp_cw) || y_nr_out !== exp_cw || out_err !== 1'b0)
        stable = 1'b0;
    end
    checks++; if (!stable) $display("FAIL hold_stable: got unstable exp stable cw=%h", exp_cw); else passed++;
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_nr_out !== '0)
      $display("FAIL hold_release: got rdy=%b vld=%b y=%h exp 1 0 0", in_ready, out_valid, y_nr_out);
    else passed++;
  endtask

  task automatic test_async_reset();
    bit ok, got;
    fill('0, BEATS - 1);
    for (int k = 0; k < BEATS; k++) q_d[k] = W'($urandom) | W'(1);
    send_frame(5, 1'b0, ok);
    in_valid = 1'b1; in_data = q_d[5]; in_last = 1'b0;
    #2 rstn = 1'b1;
    #1;
    checks++;
    if (y_nr_out !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {out_cword, out_syn, out_ok, out_err} !== '0)
      $display("FAIL async_reset: got y=%h rdy=%b vld=%b cw=%h exp reset values", y_nr_out, in_ready, out_valid, out_cword);
    else passed++;
    in_valid = 1'b0;
    #1 rstn = 1'b0;
    tick();
    fill('0, BEATS - 1);
    send_frame(BEATS, 1'b0, ok);
    wait_valid(10, got);
    checks++;
    if (!got || out_ok !== 1'b1 || out_cword !== '0 || out_err !== 1'b0)
      $display("FAIL after_reset: got ok=%b cw=%h err=%b exp 1 0 0", out_ok, out_cword, out_err);
    else passed++;
    release_out();
  endtask

  task automatic test_clr();
    bit ok, got;
    logic [NN-1:0] exp_cw;
    logic e;
    int nb;
    fill(24'hABCDEF, BEATS - 1);
    send_frame(3, 1'b0, ok);
    clr = 1'b1; in_valid = 1'b1; in_data = 24'h123456; in_last = 1'b0;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (y_nr_out !== '0 || in_ready !== 1'b1)
      $display("FAIL clr_state: got y=%h rdy=%b exp 0 1", y_nr_out, in_ready);
    else passed++;
    fill('0, BEATS - 1);
    q_d[0] = 24'h000001;
    ref_frame(exp_cw, e, nb);
    send_frame(nb, 1'b0, ok);
    wait_valid(10, got);
    checks++;
    if (!got || out_cword !== exp_cw || out_err !== 1'b0)
      $display("FAIL clr_frame: got cw=%h err=%b exp cw=%h err=0", out_cword, out_err, exp_cw);
    else passed++;
    release_out();
  endtask

  task automatic test_random();
    bit ok, got;
    logic [NN-1:0] exp_cw;
    logic e;
    int nb, r;
    for (int f = 0; f < 20; f++) begin
      fill('0, -1);
      for (int k = 0; k < BEATS; k++) q_d[k] = (f % 5 == 0) ? '0 : W'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6) q_l[BEATS - 1] = 1'b1;
      else if (r < 8) q_l[$urandom_range(0, BEATS - 2)] = 1'b1;
      ref_frame(exp_cw, e, nb);
      send_frame(nb, 1'b1, ok);
      wait_valid(10, got);
      checks++;
      if (!ok || !got || out_cword !== exp_cw || out_syn !== hsyn(exp_cw) ||
          out_ok !== (hsyn(exp_cw) == '0) || out_err !== e)
        $display("FAIL random_%0d: got cw=%h syn=%h ok=%b err=%b exp cw=%h syn=%h err=%b",
                 f, out_cword, out_syn, out_ok, out_err, exp_cw, hsyn(exp_cw), e);
      else passed++;
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [NN-1:0] exp_cw[3];
    logic [W-1:0]  all_d[$];
    logic e;
    int nb, idx, frames, last_cyc;
    bit acc;
    all_d.delete();
    for (int f = 0; f < 3; f++) begin
      fill('0, BEATS - 1);
      for (int k = 0; k < BEATS; k++) begin
        q_d[k] = W'($urandom);
        all_d.push_back(q_d[k]);
      end
      ref_frame(exp_cw[f], e, nb);
    end
    out_ready = 1'b1;
    idx = 0; frames = 0; last_cyc = -1;
    for (int c = 0; c < 60 && frames < 3; c++) begin
      in_valid = (idx < 3 * BEATS);
      in_data  = (idx < 3 * BEATS) ? all_d[idx] : '0;
      in_last  = (idx % BEATS) == BEATS - 1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      if (out_valid) begin
        checks++;
        if (out_cword !== exp_cw[frames] || out_err !== 1'b0)
          $display("FAIL b2b_frame_%0d: got cw=%h err=%b exp cw=%h err=0", frames, out_cword, out_err, exp_cw[frames]);
        else passed++;
        if (last_cyc >= 0) begin
          checks++;
          if (c - last_cyc != BEATS + 2)
            $display("FAIL b2b_period: got %0d exp %0d", c - last_cyc, BEATS + 2);
          else passed++;
        end
        last_cyc = c;
        frames++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++; if (frames != 3) $display("FAIL b2b_count: got %0d exp 3", frames); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_single_bit();
    test_last_mask();
    test_early_last();
    test_hold();
    test_async_reset();
    test_clr();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
